// File: rtl/fetch_unit_pkg.sv
// Shared widths, parameter defaults, FSM encodings and the IF/ID payload type for the fetch stage.
package fetch_unit_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned STATE_W = 1;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT   = 32'h0000_1008;
    localparam logic [XLEN-1:0] PC_STEP_DEFAULT    = 32'h0000_0008;
    localparam logic [XLEN-1:0] FAULT_WORD_DEFAULT = 32'hDEAD_BEEF;
    localparam logic [XLEN-1:0] BLOCK_MASK         = 32'hFFFF_FFF8;

    localparam logic [STATE_W-1:0] FETCH_RUN  = 1'b0;
    localparam logic [STATE_W-1:0] FETCH_HALT = 1'b1;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline boundary: load, hold, or invalidate the slot handed to decode.
module if_id_register
    import fetch_unit_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] d_instr,
    input  logic [XLEN-1:0] d_pc,
    input  logic            d_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic            valid
);

    if_id_t slot;

    // Clear only drops valid; instr/pc keep their last contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            slot <= '0;
        end else if (clear) begin
            slot.valid <= 1'b0;
        end else if (load) begin
            slot <= '{instr: d_instr, pc: d_pc, valid: d_valid};
        end
    end

    assign instr = slot.instr;
    assign pc    = slot.pc;
    assign valid = slot.valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the cache address, pairs returned words with
// their address, and handles stall replay, branch redirect and fault halting.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] PC_STEP    = PC_STEP_DEFAULT,
    parameter logic [XLEN-1:0] FAULT_WORD = FAULT_WORD_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] if_id_instr,
    output logic [XLEN-1:0] if_id_pc,
    output logic            if_id_valid,
    output logic            fetch_fault
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_n;
    logic [XLEN-1:0]    pc_reg;
    logic [XLEN-1:0]    pc_reg_n;
    logic [XLEN-1:0]    pc_d1;
    logic [XLEN-1:0]    pc_d1_n;
    logic               valid_d1;
    logic               valid_d1_n;
    logic               ifid_load;
    logic               ifid_clear;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= FETCH_RUN;
            pc_reg   <= RESET_PC;
            pc_d1    <= '0;
            valid_d1 <= 1'b0;
        end else begin
            state    <= state_n;
            pc_reg   <= pc_reg_n;
            pc_d1    <= pc_d1_n;
            valid_d1 <= valid_d1_n;
        end
    end

    // Priority: redirect > halt hold > fault detect > stall hold > advance.
    always_comb begin
        state_n    = state;
        pc_reg_n   = pc_reg;
        pc_d1_n    = pc_d1;
        valid_d1_n = valid_d1;
        ifid_load  = 1'b0;
        ifid_clear = 1'b0;
        if (branch_taken) begin
            state_n    = FETCH_RUN;
            pc_reg_n   = branch_target & BLOCK_MASK;
            valid_d1_n = 1'b0;
            ifid_clear = 1'b1;
        end else if (state == FETCH_HALT) begin
            valid_d1_n = 1'b0;
            ifid_clear = 1'b1;
        end else if (!stall && valid_d1 && (instruction == FAULT_WORD)) begin
            state_n    = FETCH_HALT;
            ifid_clear = 1'b1;
        end else if (!stall) begin
            pc_d1_n    = pc_reg;
            valid_d1_n = 1'b1;
            pc_reg_n   = pc_reg + PC_STEP;
            ifid_load  = 1'b1;
        end
    end

    // During a stall the in-flight address is re-read so the returned word stays paired with pc_d1.
    assign PC          = (stall && (state == FETCH_RUN)) ? pc_d1 : pc_reg;
    assign fetch_fault = (state == FETCH_HALT);

    if_id_register u_if_id (
        .clock   (clock),
        .reset   (reset),
        .load    (ifid_load),
        .clear   (ifid_clear),
        .d_instr (instruction),
        .d_pc    (pc_d1),
        .d_valid (valid_d1),
        .instr   (if_id_instr),
        .pc      (if_id_pc),
        .valid   (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random stall/branch/reset traffic
// checked against a transaction-level model of the fetch stream.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_1008;
    localparam logic [31:0] FAULT_WORD = 32'hDEAD_BEEF;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instruction;
    logic [31:0] PC;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic        fetch_fault;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_unit dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instruction   (instruction),
        .PC            (PC),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_valid   (if_id_valid),
        .fetch_fault   (fetch_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cache contents: preloaded program, fault marker at 0x1050, landing word at 0x1058.
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a >= 32'h1008 && a <= 32'h1048)
            return ((a - 32'h1008) / 8 + 1) * 32'h0101_0101;
        if (a == 32'h1050) return FAULT_WORD;
        if (a == 32'h1058) return 32'hFADE_CAFE;
        return a ^ 32'h5A5A_0000;
    endfunction

    // Cache returns data one cycle after the address is sampled.
    always @(posedge clock) instruction <= mem(PC);

    // Reference model: next address to issue, queue of issued-but-undelivered addresses.
    logic [31:0] m_next;
    logic [31:0] m_last;
    logic [31:0] m_out_pc;
    logic [31:0] m_out_instr;
    logic        m_out_valid;
    logic        m_halt;
    logic [31:0] inflight[$];

    task automatic model_edge();
        logic [31:0] addr;
        if (reset) begin
            m_next = RESET_PC; m_last = 32'h0; inflight.delete();
            m_out_pc = 32'h0; m_out_instr = 32'h0; m_out_valid = 1'b0; m_halt = 1'b0;
        end else if (branch_taken) begin
            m_next = {branch_target[31:3], 3'b000};
            inflight.delete();
            m_out_valid = 1'b0;
            m_halt = 1'b0;
        end else if (m_halt) begin
            m_out_valid = 1'b0;
        end else if (!stall) begin
            if (inflight.size() > 0 && mem(inflight[0]) == FAULT_WORD) begin
                m_halt = 1'b1;
                m_out_valid = 1'b0;
                inflight.delete();
            end else begin
                if (inflight.size() > 0) begin
                    addr = inflight.pop_front();
                    m_out_pc = addr;
                    m_out_instr = mem(addr);
                    m_out_valid = 1'b1;
                end else begin
                    m_out_valid = 1'b0;
                end
                inflight.push_back(m_next);
                m_last = m_next;
                m_next = m_next + 32'd8;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock edge, model update, then compare outputs away from the edge.
    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check("if_id_valid", 32'(if_id_valid), 32'(m_out_valid));
        check("fetch_fault", 32'(fetch_fault), 32'(m_halt));
        check("PC", PC, (stall && !m_halt) ? m_last : m_next);
        if (m_out_valid) begin
            check("if_id_pc", if_id_pc, m_out_pc);
            check("if_id_instr", if_id_instr, m_out_instr);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        step();
        step();
        check("rst_pc", if_id_pc, 32'h0);
        check("rst_instr", if_id_instr, 32'h0);
        check("rst_PC", PC, 32'h0000_1008);
        reset = 1'b0;

        // Reset release and sequential fetch.
        step();
        step();
        check("tp_pc0", if_id_pc, 32'h0000_1008);
        check("tp_instr0", if_id_instr, 32'h0101_0101);
        step();
        check("tp_pc1", if_id_pc, 32'h0000_1010);
        check("tp_instr1", if_id_instr, 32'h0202_0202);

        // Stall three cycles with 0x1018 in flight.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_PC", PC, 32'h0000_1018);
            check("stall_hold_pc", if_id_pc, 32'h0000_1010);
        end
        stall = 1'b0;
        step();
        check("tp_pc2", if_id_pc, 32'h0000_1018);
        check("tp_instr2", if_id_instr, 32'h0303_0303);
        step();
        check("tp_pc3", if_id_pc, 32'h0000_1020);
        check("tp_instr3", if_id_instr, 32'h0404_0404);

        // Redirect to an unaligned target; low bits cleared.
        branch_taken = 1'b1; branch_target = 32'h0000_100D;
        step();
        branch_taken = 1'b0;
        check("br_bubble0", 32'(if_id_valid), 32'h0);
        step();
        check("br_bubble1", 32'(if_id_valid), 32'h0);
        step();
        check("br_pc", if_id_pc, 32'h0000_1008);
        check("br_instr", if_id_instr, 32'h0101_0101);

        // Run into the fault word at 0x1050.
        for (int i = 0; i < 8; i++) step();
        check("last_pc", if_id_pc, 32'h0000_1048);
        check("last_instr", if_id_instr, 32'h0909_0909);
        step();
        check("fault_flag", 32'(fetch_fault), 32'h1);
        check("fault_valid", 32'(if_id_valid), 32'h0);
        stall = 1'b1;
        step();
        step();
        check("halt_PC", PC, 32'h0000_1058);

        // Redirect out of HALT with stall asserted in the same cycle.
        branch_taken = 1'b1; branch_target = 32'h0000_1058;
        step();
        branch_taken = 1'b0; stall = 1'b0;
        check("br_clears_fault", 32'(fetch_fault), 32'h0);
        step();
        step();
        check("land_pc", if_id_pc, 32'h0000_1058);
        check("land_instr", if_id_instr, 32'hFADE_CAFE);

        // PC wrap at the top of the address space.
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFF8;
        step();
        branch_taken = 1'b0;
        check("wrap_PC0", PC, 32'hFFFF_FFF8);
        step();
        check("wrap_PC1", PC, 32'h0000_0000);
        step();
        check("wrap_if_pc0", if_id_pc, 32'hFFFF_FFF8);
        step();
        check("wrap_if_pc1", if_id_pc, 32'h0000_0000);

        // Reset in the middle of a stall.
        stall = 1'b1;
        step();
        reset = 1'b1;
        step();
        check("rst_stall_valid", 32'(if_id_valid), 32'h0);
        check("rst_stall_pc", if_id_pc, 32'h0);
        reset = 1'b0; stall = 1'b0;

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 99) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 11) == 0);
            branch_target = ($urandom_range(0, 3) == 0) ? 32'($urandom())
                                                         : 32'h1000 + 32'($urandom_range(0, 127));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
